// File: rtl/ram_access_unit.sv
// ram_access_unit
//   Load/store front end for a 256 x 32-bit byte-enabled simple dual-port RAM
//   that has a registered read port. The unit accepts one byte, half or word
//   request at a time on a valid/ready handshake. It turns stores into
//   lane-replicated write data plus byte strobes. It turns loads into a RAM
//   read, then extracts the addressed lane and extends it. Every accepted
//   request produces exactly one response pulse.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_we                1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned          zero-extend loads when 1, sign-extend when 0
//   req_addr              byte address
//   req_wdata             right-aligned store data
//   resp_valid            one-cycle response pulse (no back-pressure)
//   resp_rdata            load result, 0 for stores and errors
//   resp_err              misaligned / illegal request flag
//   ram_we/ram_be         RAM write enable and per-byte enables
//   ram_wdata/ram_waddr   RAM write data and word address
//   ram_raddr             RAM read word address (combinational from req_addr)
//   ram_q                 RAM read data, valid one cycle after ram_raddr sampled
module ram_access_unit #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  ram_we,
    output logic [3:0]            ram_be,
    output logic [31:0]           ram_wdata,
    output logic [ADDR_WIDTH-3:0] ram_waddr,
    output logic [ADDR_WIDTH-3:0] ram_raddr,
    input  logic [31:0]           ram_q
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic                  ram_we_q, ram_we_d;
    logic [3:0]            ram_be_q, ram_be_d;
    logic [31:0]           ram_wdata_q, ram_wdata_d;
    logic [ADDR_WIDTH-3:0] ram_waddr_q, ram_waddr_d;
    // Load attributes captured at acceptance; the request bus is free to
    // change while the RAM read is in progress.
    logic [1:0]            ld_off_q, ld_off_d;
    logic [1:0]            ld_size_q, ld_size_d;
    logic                  ld_uns_q, ld_uns_d;

    function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicating the source across all lanes lets the byte enables alone
    // select the destination lane, so no shifter is needed on the write path.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                                 input logic [1:0]  off,
                                                 input logic        uns,
                                                 input logic [31:0] q);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = q[7:0];
            2'd1:    b = q[15:8];
            2'd2:    b = q[23:16];
            default: b = q[31:24];
        endcase
        h = off[1] ? q[31:16] : q[15:0];
        case (size)
            2'b00:   r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = q;
        endcase
        return r;
    endfunction

    // The RAM samples the read address every edge; only the sample taken at
    // load acceptance is consumed, so no register is needed here.
    assign ram_raddr = req_addr[ADDR_WIDTH-1:2];

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign ram_we     = ram_we_q;
    assign ram_be     = ram_be_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_waddr  = ram_waddr_q;

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'b0;
        resp_err_d   = 1'b0;
        ram_we_d     = 1'b0;
        ram_be_d     = 4'b0;
        ram_wdata_d  = ram_wdata_q;
        ram_waddr_d  = ram_waddr_q;
        ld_off_d     = ld_off_q;
        ld_size_d    = ld_size_q;
        ld_uns_d     = ld_uns_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (is_bad_req(req_size, req_addr[1:0])) begin
                        // Errors answer immediately and never touch the RAM.
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_we) begin
                        ram_we_d    = 1'b1;
                        ram_be_d    = store_be(req_size, req_addr[1:0]);
                        ram_wdata_d = store_data(req_size, req_wdata);
                        ram_waddr_d = req_addr[ADDR_WIDTH-1:2];
                        state_d     = S_WR;
                    end else begin
                        ld_off_d  = req_addr[1:0];
                        ld_size_d = req_size;
                        ld_uns_d  = req_unsigned;
                        state_d   = S_RD;
                    end
                end
            end
            S_WR: begin
                // The RAM commits the write at the edge that ends this state.
                resp_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            S_RD: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = load_extract(ld_size_q, ld_off_q, ld_uns_q, ram_q);
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Everything resets asynchronously so a pending write strobe is cancelled
    // the moment reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'b0;
            resp_err_q   <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_be_q     <= 4'b0;
            ram_wdata_q  <= 32'b0;
            ram_waddr_q  <= '0;
            ld_off_q     <= 2'b0;
            ld_size_q    <= 2'b0;
            ld_uns_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            ram_we_q     <= ram_we_d;
            ram_be_q     <= ram_be_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_waddr_q  <= ram_waddr_d;
            ld_off_q     <= ld_off_d;
            ld_size_q    <= ld_size_d;
            ld_uns_q     <= ld_uns_d;
        end
    end

endmodule

// File: doc/ram_access_unit.md
# ram_access_unit

Load/store front end for the byte-enabled simple dual-port data RAM (256 x 32-bit, registered read, per-byte write enables). It takes single byte/half/word requests from the core on a valid/ready handshake. It turns them into RAM write strobes with lane-replicated data, or into RAM reads with lane extraction and sign/zero extension. It returns exactly one response per accepted request, and keeps one request in flight at a time so that read-during-write hazards cannot occur.

## Interface
Parameters:
- ADDR_WIDTH, 10, byte-address width. The RAM word address is req_addr[ADDR_WIDTH-1:2], 8 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse. There is no back-pressure.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal request, valid with resp_valid.
- ram_we  out  1  RAM write enable.
- ram_be  out  4  RAM byte enables; bit i enables byte i (bits 8i+7:8i).
- ram_wdata  out  32  RAM write data.
- ram_waddr  out  8  RAM write word address.
- ram_raddr  out  8  RAM read word address.
- ram_q  in  32  RAM registered read data, valid one cycle after ram_raddr is sampled.

## Operation
- States are IDLE, WR and RD. Acceptance is req_valid & req_ready at a rising edge.
- ram_raddr = req_addr[9:2] combinationally at all times. The RAM samples it every edge; only the sample taken at acceptance is used.
- Error check happens at acceptance. A request is in error when:
  - size is 11, or
  - size is half and addr[0]=1, or
  - size is word and addr[1:0]≠00.
- An erroring request:
  - makes no RAM write;
  - registers resp_valid=1, resp_err=1, resp_rdata=0;
  - leaves the unit in IDLE.
- Store accept registers ram_we=1, ram_waddr=addr[9:2], and the following, then goes to WR:
  - byte: ram_be = 0001 << addr[1:0], ram_wdata = {4{wdata[7:0]}}.
  - half: ram_be = addr[1] ? 1100 : 0011, ram_wdata = {2{wdata[15:0]}}.
  - word: ram_be = 1111, ram_wdata = wdata.
- WR lasts one cycle. The RAM writes at the next edge, where the unit registers ram_we=0, ram_be=0, resp_valid=1, resp_err=0, resp_rdata=0, and returns to IDLE. ram_wdata and ram_waddr hold their last values.
- Load accept latches addr[1:0], size and unsigned, then goes to RD.
- In RD, ram_q is valid. At the next edge the unit registers resp_valid=1, resp_err=0 and resp_rdata, then returns to IDLE. resp_rdata is formed as:
  - byte: lane = ram_q[8·off+7:8·off], extended to 32 bits.
  - half: lane = ram_q[16·addr[1]+15 : 16·addr[1]], extended to 32 bits.
  - word: ram_q unchanged.
- resp_valid is high for exactly one cycle per accepted request. A new request may be accepted in the cycle in which resp_valid is high.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, ram_we 0, ram_be 0, ram_wdata 0, ram_waddr 0. ram_raddr follows req_addr.
- Latency is counted from the acceptance edge E0:
  - error response visible after E0 (1 edge);
  - store response and RAM write at E1 (2 edges);
  - load response after E1 (2 edges).
- Throughput is at most one request every 2 cycles for loads and stores, and one per cycle for errors.
- A load accepted immediately after a store response reads at an edge later than the write edge, so it always sees the new data.
- Reset asserted mid-operation: the pending store is cancelled because ram_we clears asynchronously and no write occurs. A pending load is dropped and gives no response. After reset release the unit is in IDLE.
- Request inputs are ignored whenever req_ready=0.

## Test plan
- Store word 0xDEADBEEF at 0x004 -> ram_we=1 with ram_be=1111 and ram_waddr=1 for exactly one cycle. resp_valid is high 2 edges after accept. A load word from 0x004 then returns 0xDEADBEEF.
- Store bytes 0x11, 0x22, 0x33, 0x84 at 0x010..0x013 -> ram_be steps through 0001, 0010, 0100, 1000 with ram_wdata = {4{byte}}. A load word from 0x010 returns 0x84332211.
- From that data: signed byte load at 0x013 -> 0xFFFFFF84; unsigned byte load -> 0x00000084; signed half load at 0x012 -> 0xFFFF8433; unsigned half load at 0x010 -> 0x00002211.
- Half store at 0x021, word load at 0x022, and size=11 at 0x000 -> each gives resp_err=1 and resp_rdata=0 one edge after accept, with no ram_we pulse. req_ready stays 1.
- Back-to-back traffic with req_valid held high, alternating store and load to the same word -> req_ready low in WR/RD, one resp_valid per request, and every load returns the immediately preceding store's data.
- Assert rst_n low during WR of a store to 0x030 -> ram_we drops immediately and no resp_valid appears. A subsequent load of 0x030 returns the pre-store contents.
